// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with wrap or saturate behaviour at the range bounds.
// cnt and wrap are registered; tc is a combinational look-ahead of the boundary step.
module updown_mod_counter #(
  parameter int N        = 8,
  parameter int MODULUS  = 2**N,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         up,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] load_value,
  output logic [N-1:0] cnt,
  output logic         tc,
  output logic         wrap
);

  // MODULUS may equal 2**N, so the top of range is formed in N bits directly.
  localparam logic [N-1:0] CNT_MAX = N'(MODULUS - 1);
  localparam logic [N-1:0] CNT_ONE = N'(1);

  logic [N-1:0] r_cnt;
  logic         r_wrap;
  logic [N-1:0] w_cnt_nxt;
  logic         w_wrap_nxt;
  logic         w_at_max;
  logic         w_at_min;
  logic         w_bound;

  function automatic logic [N-1:0] clamp_load(input logic [N-1:0] v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  assign w_at_max = (r_cnt == CNT_MAX);
  assign w_at_min = (r_cnt == '0);
  assign w_bound  = enable & ((up & w_at_max) | (~up & w_at_min));

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    if (clear) begin
      w_cnt_nxt = '0;
    end else if (load) begin
      w_cnt_nxt = clamp_load(load_value);
    end else if (enable) begin
      if (w_bound) begin
        // Boundary step: saturate holds the bound, wrap jumps to the other end.
        w_wrap_nxt = 1'b1;
        if (!SATURATE) begin
          w_cnt_nxt = up ? '0 : CNT_MAX;
        end
      end else begin
        w_cnt_nxt = up ? (r_cnt + CNT_ONE) : (r_cnt - CNT_ONE);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign cnt  = r_cnt;
  assign wrap = r_wrap;
  assign tc   = w_bound;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: three configurations share one clock.
// Each vector pushes the cnt/wrap/tc expected at the following falling edge.
module tb_updown_mod_counter;

  logic       clock;
  logic       rst_n [3];
  logic       en    [3];
  logic       up    [3];
  logic       clr   [3];
  logic       ld    [3];
  logic [3:0] lv    [3];

  logic [3:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic       tc_a, tc_b, tc_c;
  logic       wrap_a, wrap_b, wrap_c;

  typedef struct {
    int         id;
    int         seq;
    logic [3:0] cnt;
    logic       wrap;
    logic       tc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   seq_no = 0;
  bit   stim_done = 1'b0;

  // A: N=4 MODULUS=10 wrap; B: N=4 MODULUS=16 saturate; C: N=2 MODULUS=4 wrap.
  updown_mod_counter #(.N(4), .MODULUS(10), .SATURATE(1'b0)) u_a (
    .clock(clock), .reset_n(rst_n[0]), .enable(en[0]), .up(up[0]), .clear(clr[0]),
    .load(ld[0]), .load_value(lv[0]), .cnt(cnt_a), .tc(tc_a), .wrap(wrap_a));

  updown_mod_counter #(.N(4), .MODULUS(16), .SATURATE(1'b1)) u_b (
    .clock(clock), .reset_n(rst_n[1]), .enable(en[1]), .up(up[1]), .clear(clr[1]),
    .load(ld[1]), .load_value(lv[1]), .cnt(cnt_b), .tc(tc_b), .wrap(wrap_b));

  updown_mod_counter #(.N(2), .MODULUS(4), .SATURATE(1'b0)) u_c (
    .clock(clock), .reset_n(rst_n[2]), .enable(en[2]), .up(up[2]), .clear(clr[2]),
    .load(ld[2]), .load_value(lv[2][1:0]), .cnt(cnt_c), .tc(tc_c), .wrap(wrap_c));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic drive(input int id, input bit r, input bit e, input bit u,
                       input bit c, input bit l, input logic [3:0] v,
                       input logic [3:0] ec, input bit ew, input bit et);
    exp_t x;
    @(posedge clock);
    #1;
    rst_n[id] = r;
    en[id]    = e;
    up[id]    = u;
    clr[id]   = c;
    ld[id]    = l;
    lv[id]    = v;
    x.id   = id;
    x.seq  = seq_no;
    x.cnt  = ec;
    x.wrap = ew;
    x.tc   = et;
    q.push_back(x);
    seq_no++;
  endtask

  task automatic check(input string name, input int seq, input logic [3:0] got,
                       input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec %0d got %0d want %0d", name, seq, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [3:0] o_cnt;
      logic       o_wrap, o_tc;
      e = q.pop_front();
      case (e.id)
        0:       begin o_cnt = cnt_a;         o_wrap = wrap_a; o_tc = tc_a; end
        1:       begin o_cnt = cnt_b;         o_wrap = wrap_b; o_tc = tc_b; end
        default: begin o_cnt = {2'b00, cnt_c}; o_wrap = wrap_c; o_tc = tc_c; end
      endcase
      check("cnt",  e.seq, o_cnt, e.cnt);
      check("wrap", e.seq, {3'b000, o_wrap}, {3'b000, e.wrap});
      check("tc",   e.seq, {3'b000, o_tc},   {3'b000, e.tc});
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; en[i] = 1'b0; up[i] = 1'b0;
      clr[i] = 1'b0;   ld[i] = 1'b0; lv[i] = 4'd0;
    end

    // ---- DUT A: reset, count up through the wrap
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      drive(0, 1, 1, 1, 0, 0, 0, 4'(i % 10), (i == 10), ((i % 10) == 9));
    drive(0, 1, 0, 0, 0, 0, 0, 2, 0, 0);
    // load 3 then count down through 0 -> 9
    drive(0, 1, 0, 0, 0, 1, 3, 2, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 3, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 2, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 0, 0, 9, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 8, 0, 0);
    // load out of range clamps, then clear beats load/enable at the bound
    drive(0, 1, 0, 0, 0, 1, 15, 8, 0, 0);
    drive(0, 1, 1, 1, 1, 1, 5, 9, 0, 1);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // direction toggling from 5
    drive(0, 1, 0, 0, 0, 1, 5, 0, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0, 5, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 6, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0, 5, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 6, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 5, 0, 0);
    // asynchronous reset overrides load and enable mid-count
    drive(0, 1, 1, 1, 0, 0, 0, 5, 0, 0);
    drive(0, 0, 1, 1, 0, 1, 7, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 1, 7, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---- DUT B: saturate mode at both bounds
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 1, 14, 0, 0, 0);
    drive(1, 1, 1, 1, 0, 0, 0, 14, 0, 0);
    drive(1, 1, 1, 1, 0, 0, 0, 15, 0, 1);
    drive(1, 1, 1, 1, 0, 0, 0, 15, 1, 1);
    drive(1, 1, 1, 1, 0, 0, 0, 15, 1, 1);
    drive(1, 1, 1, 0, 0, 0, 0, 15, 1, 0);
    drive(1, 1, 0, 0, 0, 1, 0, 14, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---- DUT C: full-range modulus, reset in the middle of a count
    drive(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(2, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(2, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    drive(2, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(2, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(2, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    drive(2, 1, 1, 1, 0, 0, 0, 2, 0, 0);
    drive(2, 1, 1, 1, 0, 0, 0, 3, 0, 1);
    drive(2, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++)
      drive(2, 1, 1, 1, 0, 0, 0, 4'(i % 4), (i == 4), ((i % 4) == 3));
    drive(2, 1, 0, 0, 0, 0, 0, 0, 1, 0);

    @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", q.size());
    end
    stim_done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    if (!stim_done) begin
      $display("FAIL timeout got stuck want finished");
      $fatal(1, "timeout");
    end
  end

endmodule
